// File: rtl/enemy_motion_ctrl_if.sv
// Coordinate and scan-control bundle between the enemy motion sequencer
// (master) and the enemy sprite datapath (slave).
interface enemy_motion_ctrl_if;
    logic [79:0] x_flat;
    logic [79:0] y_flat;
    logic [9:0]  visible;
    logic        load_coord;
    logic        enable;
    logic [1:0]  op;

    modport master (
        output x_flat, y_flat, visible, load_coord, enable, op
    );

    modport slave (
        input x_flat, y_flat, visible, load_coord, enable, op
    );
endinterface

// File: rtl/enemy_motion_ctrl.sv
// Frame sequencer for the 10-enemy sprite datapath: erase pass, coordinate
// update, load strobe, draw pass. Owns enemy positions, visibility and kills.
module enemy_motion_ctrl #(
    parameter int PASS_CYCLES = 250,
    parameter int Y_LIMIT     = 115,
    parameter int STEP        = 1,
    parameter int MOVE_DIV    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 frame_tick_i,
    input  logic                 hit_valid_i,
    input  logic [3:0]           hit_index_i,
    enemy_motion_ctrl_if.master  dp,
    output logic                 busy_o,
    output logic                 bottom_hit_o,
    output logic [3:0]           bottom_count_o,
    output logic                 frame_overrun_o
);

    localparam int CNT_W = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PASS_CYCLES - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(MOVE_DIV - 1);
    localparam logic [79:0] X_INIT = {8'd142, 8'd12, 8'd2, 8'd42, 8'd32,
                                      8'd72, 8'd122, 8'd62, 8'd82, 8'd102};

    typedef enum logic [2:0] {
        S_WAIT,
        S_ERASE,
        S_UPDATE,
        S_LOAD,
        S_DRAW
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] passCnt_q;
    logic [DIV_W-1:0] frameDiv_q;
    logic [9:0]       pendingKill_q;
    logic [79:0]      xFlat_q;
    logic [79:0]      yFlat_q;
    logic [9:0]       visible_q;
    logic             loadCoord_q;
    logic             enable_q;
    logic [1:0]       op_q;
    logic             busy_q;
    logic             bottomHit_q;
    logic [3:0]       bottomCount_q;
    logic             overrun_q;

    logic [79:0]      yNext_d;
    logic [9:0]       respawn_d;
    logic [3:0]       bottomCount_d;
    logic [9:0]       hitMask_d;
    logic [8:0]       ny;
    logic             move;

    assign move = (frameDiv_q == LAST_DIV);

    // Candidate positions for every enemy, computed in parallel; only
    // committed in the UPDATE cycle of a move frame.
    always_comb begin
        yNext_d       = yFlat_q;
        respawn_d     = '0;
        bottomCount_d = '0;
        ny            = '0;
        for (int i = 0; i < 10; i++) begin
            ny = {1'b0, yFlat_q[8*i +: 8]} + 9'(STEP);
            if (ny >= 9'(Y_LIMIT)) begin
                yNext_d[8*i +: 8] = 8'd0;
                respawn_d[i]      = 1'b1;
                if (visible_q[i]) begin
                    bottomCount_d = bottomCount_d + 4'd1;
                end
            end else begin
                yNext_d[8*i +: 8] = ny[7:0];
            end
        end
        hitMask_d = '0;
        if (hit_valid_i && (hit_index_i < 4'd10)) begin
            hitMask_d = 10'(1) << hit_index_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_WAIT;
            passCnt_q     <= '0;
            frameDiv_q    <= '0;
            pendingKill_q <= '0;
            xFlat_q       <= X_INIT;
            yFlat_q       <= '0;
            visible_q     <= 10'h3FF;
            loadCoord_q   <= 1'b0;
            enable_q      <= 1'b0;
            op_q          <= 2'b00;
            busy_q        <= 1'b0;
            bottomHit_q   <= 1'b0;
            bottomCount_q <= '0;
            overrun_q     <= 1'b0;
        end else begin
            loadCoord_q   <= 1'b0;
            bottomHit_q   <= 1'b0;
            bottomCount_q <= '0;
            overrun_q     <= frame_tick_i && (state_q != S_WAIT);
            pendingKill_q <= pendingKill_q | hitMask_d;

            case (state_q)
                S_WAIT: begin
                    if (frame_tick_i) begin
                        state_q   <= S_ERASE;
                        passCnt_q <= '0;
                        enable_q  <= 1'b1;
                        op_q      <= 2'b01;
                        busy_q    <= 1'b1;
                    end
                end
                S_ERASE: begin
                    if (passCnt_q == LAST_CNT) begin
                        state_q   <= S_UPDATE;
                        passCnt_q <= '0;
                        enable_q  <= 1'b0;
                    end else begin
                        passCnt_q <= passCnt_q + CNT_W'(1);
                    end
                end
                S_UPDATE: begin
                    state_q       <= S_LOAD;
                    loadCoord_q   <= 1'b1;
                    op_q          <= 2'b00;
                    // A hit landing in this very cycle must survive into the next frame.
                    pendingKill_q <= hitMask_d;
                    if (move) begin
                        frameDiv_q    <= '0;
                        yFlat_q       <= yNext_d;
                        visible_q     <= (visible_q | respawn_d) & ~pendingKill_q;
                        bottomCount_q <= bottomCount_d;
                        bottomHit_q   <= (bottomCount_d != 4'd0);
                    end else begin
                        frameDiv_q    <= frameDiv_q + DIV_W'(1);
                        visible_q     <= visible_q & ~pendingKill_q;
                    end
                end
                S_LOAD: begin
                    state_q   <= S_DRAW;
                    passCnt_q <= '0;
                    enable_q  <= 1'b1;
                end
                S_DRAW: begin
                    if (passCnt_q == LAST_CNT) begin
                        state_q   <= S_WAIT;
                        passCnt_q <= '0;
                        enable_q  <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        passCnt_q <= passCnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= S_WAIT;
                    enable_q <= 1'b0;
                    op_q     <= 2'b00;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign dp.x_flat     = xFlat_q;
    assign dp.y_flat     = yFlat_q;
    assign dp.visible    = visible_q;
    assign dp.load_coord = loadCoord_q;
    assign dp.enable     = enable_q;
    assign dp.op         = op_q;

    assign busy_o          = busy_q;
    assign bottom_hit_o    = bottomHit_q;
    assign bottom_count_o  = bottomCount_q;
    assign frame_overrun_o = overrun_q;

endmodule
